uart_packet_tx: RTL

Transmit-side packet framer feeding the byte-level RS-232 transmitter (data/send/sending handshake). It buffers a payload, then emits a packet in the same format the receive-side demux decodes: checksum byte, address byte, count byte (payload length − 1), then payload bytes. The checksum is chosen so that the 8-bit sum of every byte in the packet is 0. It lets FPGA-side logic report state back to the host over the same link used for host→FPGA writes.

---
 rtl/uart_packet_tx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_packet_tx.sv
// Packet framer in front of a byte-level UART transmitter: buffers payload bytes, then
// sends checksum, address, (length-1) and the payload over the send/sending handshake.
module uart_packet_tx #(
  parameter int ADDR_BITS = 4
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [7:0] in_data,
  input  logic       in_write,
  output logic       in_ready,
  input  logic [7:0] pkt_addr,
  input  logic       pkt_start,
  output logic       busy,
  output logic       done,
  output logic       drop,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_sending
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int PW    = ADDR_BITS + 1;

  typedef enum logic [2:0] {
    IDLE, CK, ADR, CNT, DAT, SEND, WHI, WLO
  } state_e;

  state_e        state_q, state_d;
  state_e        byte_q, byte_d;
  logic [PW-1:0] wcnt_q, wcnt_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    ck_q, ck_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          tx_send_q, tx_send_d;

  logic [7:0]    mem_q [DEPTH];

  logic          full;
  logic          wr_accept;
  logic [PW-1:0] wcnt_eff;
  logic [8:0]    wcnt_ext;
  logic [7:0]    sum_eff;
  logic [7:0]    cnt_new;
  logic [7:0]    ck_new;
  logic [7:0]    byte_mux;
  logic          last_byte;

  assign full      = (wcnt_q == PW'(DEPTH));
  assign in_ready  = (state_q == IDLE) && !full;
  assign wr_accept = in_write && in_ready;

  // Header fields include a byte written in the same cycle as pkt_start.
  assign wcnt_eff  = wcnt_q + PW'(wr_accept);
  assign wcnt_ext  = 9'(wcnt_eff);
  assign sum_eff   = sum_q + (wr_accept ? in_data : 8'h00);
  assign cnt_new   = 8'(wcnt_ext - 9'd1);
  assign ck_new    = 8'h00 - (sum_eff + pkt_addr + cnt_new);
  assign last_byte = ((rptr_q + PW'(1)) == wcnt_q);

  // NOTE: the payload RAM has no reset; bytes at or above wcnt are never read.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wcnt_q[ADDR_BITS-1:0]] <= in_data;
  end

  always_comb begin
    case (state_q)
      CK:      byte_mux = ck_q;
      ADR:     byte_mux = addr_q;
      CNT:     byte_mux = cnt_q;
      default: byte_mux = mem_q[rptr_q[ADDR_BITS-1:0]];
    endcase
  end

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    wcnt_d    = wcnt_q;
    rptr_d    = rptr_q;
    sum_d     = sum_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    ck_d      = ck_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_send_d = 1'b0;
    drop_d    = drop_q | (in_write & ~in_ready);

    if (wr_accept) begin
      wcnt_d = wcnt_eff;
      sum_d  = sum_eff;
    end

    case (state_q)
      IDLE: begin
        if (pkt_start && (wcnt_eff != '0)) begin
          addr_d    = pkt_addr;
          cnt_d     = cnt_new;
          ck_d      = ck_new;
          tx_data_d = ck_new;
          busy_d    = 1'b1;
          state_d   = CK;
        end
      end
      // Byte states only hand over once the line is quiet.
      CK, ADR, CNT, DAT: begin
        if (!tx_sending) begin
          byte_d    = state_q;
          tx_data_d = byte_mux;
          tx_send_d = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: state_d = WHI;
      WHI: begin
        if (tx_sending) state_d = WLO;
      end
      WLO: begin
        if (!tx_sending) begin
          case (byte_q)
            CK:  state_d = ADR;
            ADR: state_d = CNT;
            CNT: state_d = DAT;
            default: begin
              rptr_d = rptr_q + PW'(1);
              if (last_byte) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                wcnt_d  = '0;
                rptr_d  = '0;
                sum_d   = 8'h00;
                state_d = IDLE;
              end else begin
                state_d = DAT;
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= IDLE;
      byte_q    <= CK;
      wcnt_q    <= '0;
      rptr_q    <= '0;
      sum_q     <= 8'h00;
      addr_q    <= 8'h00;
      cnt_q     <= 8'h00;
      ck_q      <= 8'h00;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      tx_send_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      wcnt_q    <= wcnt_d;
      rptr_q    <= rptr_d;
      sum_q     <= sum_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ck_q      <= ck_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
      tx_send_q <= tx_send_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign drop    = drop_q;
  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;

endmodule
